cntr_reload_timer: RTL

CNTR_RELOAD_TIMER -- requirements
Module: cntr_reload_timer

---
 rtl/cntr_pkg.sv | 16 +
 rtl/register_nbit.sv | 28 ++
 rtl/cntr_reload_timer.sv | 118 +++++++++++
 3 files changed

// File: rtl/cntr_pkg.sv
// cntr_pkg -- shared constants for the reload timer.
//   DEFAULT_WIDTH / DEFAULT_PRESCALE_W : default counter and prescaler widths
//   DIR_UP / DIR_DOWN                  : encoding of the dir_down input
//   MODE_PERIODIC / MODE_ONESHOT       : encoding of the mode_oneshot input
package cntr_pkg;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_PRESCALE_W = 4;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/register_nbit.sv
// register_nbit -- WIDTH-bit load-enabled holding register.
// Ports:
//   CLK      : clock, rising edge
//   RST      : synchronous active-high reset, clears the register
//   load     : capture data_in on the next edge
//   data_in  : value to capture
//   data_out : stored value
module register_nbit
  import cntr_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_out <= '0;
    end else if (load) begin
      data_out <= data_in;
    end
  end

endmodule

// File: rtl/cntr_reload_timer.sv
// cntr_reload_timer -- up/down counter with reload register, periodic or
// one-shot operation, registered terminal-count pulse and sticky interrupt.
// Optional feature macro: CNTR_PRESCALER_EN adds the presc port and a
// PRESCALE_W-bit prescaler that gates the count step.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   en           : count enable
//   load/data_in : write data_in into the reload register
//   re_load      : restart counter from the reload value
//   dir_down     : 0 = count up to all-ones, 1 = count down to zero
//   mode_oneshot : 0 = periodic, 1 = one-shot
//   irq_clr      : clear the sticky interrupt
//   presc        : prescale divisor minus one (CNTR_PRESCALER_EN only)
//   data_out     : current count
//   tc           : one-cycle terminal-count pulse, registered
//   running      : counter active
//   irq          : sticky terminal-count flag
module cntr_reload_timer
  import cntr_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  re_load,
  input  logic                  dir_down,
  input  logic                  mode_oneshot,
  input  logic                  irq_clr,
`ifdef CNTR_PRESCALER_EN
  input  logic [PRESCALE_W-1:0] presc,
`endif
  output logic [WIDTH-1:0]      data_out,
  output logic                  tc,
  output logic                  running,
  output logic                  irq
);

  if (WIDTH < 2 || PRESCALE_W < 1) begin : g_param_check
    $error("cntr_reload_timer: WIDTH must be >= 2 and PRESCALE_W >= 1");
  end

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  function automatic logic at_terminal(input logic [WIDTH-1:0] c, input logic down);
    return (down == DIR_DOWN) ? (c == '0) : (c == ALL_ONES);
  endfunction

  logic [WIDTH-1:0] reload_val;
  logic             presc_hit;
  logic             tick;
  logic             term;

  register_nbit #(.WIDTH(WIDTH)) u_reload (
    .CLK      (clk),
    .RST      (rst),
    .load     (load),
    .data_in  (data_in),
    .data_out (reload_val)
  );

`ifdef CNTR_PRESCALER_EN
  logic [PRESCALE_W-1:0] presc_cnt;

  // >= rather than == so that lowering presc mid-phase cannot strand the
  // count above the new divisor.
  assign presc_hit = (presc_cnt >= presc);

  always_ff @(posedge clk) begin
    if (rst || re_load) begin
      presc_cnt <= '0;
    end else if (en && running) begin
      presc_cnt <= presc_hit ? '0 : presc_cnt + 1'b1;
    end
  end
`else
  assign presc_hit = 1'b1;
`endif

  assign tick = en & running & presc_hit;
  assign term = at_terminal(data_out, dir_down);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      running  <= 1'b1;
      tc       <= 1'b0;
      irq      <= 1'b0;
    end else begin
      tc  <= 1'b0;
      // irq follows the registered tc, so a clear seen alongside a visible
      // tc pulse loses to the set.
      irq <= tc | (irq & ~irq_clr);
      if (re_load) begin
        // load in the same cycle bypasses the reload register
        data_out <= load ? data_in : reload_val;
        running  <= 1'b1;
      end else if (tick) begin
        if (term) begin
          tc <= 1'b1;
          if (mode_oneshot == MODE_ONESHOT) begin
            running <= 1'b0;
          end else begin
            data_out <= reload_val;
          end
        end else if (dir_down == DIR_DOWN) begin
          data_out <= data_out - 1'b1;
        end else begin
          data_out <= data_out + 1'b1;
        end
      end
    end
  end

endmodule
